// File: rtl/pwm_capture_pkg.sv
// Shared types and default constants for the PWM period/duty capture block.
package pwm_capture_pkg;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_DUTY_W  = 7;
  localparam int DEF_TIMEOUT = 10_000_000;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider, one quotient bit per clock, MSB first.
// The first bit is resolved on the start edge, so done pulses Q_W-1 cycles after start.
module pwm_duty_div #(
  parameter int DEN_W = 32,
  parameter int Q_W   = 7,
  localparam int NUM_W = DEN_W + Q_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int SW = $clog2(Q_W + 1);

  logic [NUM_W-1:0] rem_reg, rem_src, rem_next, den_sh;
  logic [DEN_W-1:0] den_reg, den_src;
  logic [SW-1:0]    step_reg, step_src;
  logic [Q_W-1:0]   q_reg, q_src, q_next;
  logic             busy_reg, done_reg, fits;

  always_comb begin
    rem_src  = start ? numerator : rem_reg;
    den_src  = start ? denominator : den_reg;
    step_src = start ? SW'(Q_W - 1) : step_reg;
    q_src    = start ? '0 : q_reg;
    den_sh   = NUM_W'(den_src) << step_src;
    fits     = (rem_src >= den_sh);
    rem_next = fits ? (rem_src - den_sh) : rem_src;
    q_next   = q_src | (Q_W'(fits) << step_src);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg  <= '0;
      den_reg  <= '0;
      step_reg <= '0;
      q_reg    <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start || busy_reg) begin
        rem_reg  <= rem_next;
        den_reg  <= den_src;
        q_reg    <= q_next;
        step_reg <= step_src - 1'b1;
        busy_reg <= (step_src != '0);
        done_reg <= (step_src == '0);
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign quotient = q_reg;

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and scaled duty of an asynchronous PWM input,
// and flags an input that stops toggling.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DUTY_W  = DEF_DUTY_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck_high,
  output logic              stuck_low
);

  localparam int NUM_W = CNT_W + DUTY_W;

  state_t            state_reg;
  logic              sync1_reg, sync2_reg, prev_reg;
  logic [2:0]        prime_reg;
  logic [CNT_W-1:0]  cnt_reg, high_reg, idle_reg;
  logic [CNT_W-1:0]  pend_period_reg, pend_high_reg;
  logic [CNT_W-1:0]  period_reg, high_time_reg;
  logic [DUTY_W-1:0] duty_reg, div_q;
  logic              valid_reg, stuck_high_reg, stuck_low_reg;
  logic              rise, fall, timeout, div_start, div_busy, div_done;
  logic [NUM_W-1:0]  div_num;

  // Edges are only trusted once the synchronizer and edge flop hold real samples,
  // so an input already high at reset release does not look like a rising edge.
  assign rise    = prime_reg[2] & sync2_reg & ~prev_reg;
  assign fall    = prime_reg[2] & ~sync2_reg & prev_reg;
  assign timeout = ~(rise | fall) & (idle_reg == CNT_W'(TIMEOUT - 1));

  // Periods this short would land while the previous division is still in flight.
  assign div_start = (state_reg == LOW) & rise & (cnt_reg > CNT_W'(DUTY_W + 1))
                   & ~div_busy & ~div_done & ~valid_reg;
  assign div_num   = {high_reg, {DUTY_W{1'b0}}} - NUM_W'(high_reg);

  pwm_duty_div #(
    .DEN_W (CNT_W),
    .Q_W   (DUTY_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .numerator   (div_num),
    .denominator (cnt_reg),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      prev_reg        <= 1'b0;
      prime_reg       <= '0;
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      high_reg        <= '0;
      idle_reg        <= '0;
      pend_period_reg <= '0;
      pend_high_reg   <= '0;
      period_reg      <= '0;
      high_time_reg   <= '0;
      duty_reg        <= '0;
      valid_reg       <= 1'b0;
      stuck_high_reg  <= 1'b0;
      stuck_low_reg   <= 1'b0;
    end else begin
      sync1_reg <= pwm_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      prime_reg <= {prime_reg[1:0], 1'b1};

      if (rise)
        cnt_reg <= CNT_W'(1);
      else if (cnt_reg != '1)
        cnt_reg <= cnt_reg + 1'b1;

      if (rise | fall)
        idle_reg <= '0;
      else if (idle_reg != CNT_W'(TIMEOUT))
        idle_reg <= idle_reg + 1'b1;

      case (state_reg)
        IDLE: if (rise) state_reg <= HIGH;
        HIGH: if (fall) begin
          high_reg  <= cnt_reg;
          state_reg <= LOW;
        end
        LOW: if (rise) state_reg <= HIGH;
        default: state_reg <= IDLE;
      endcase

      if (div_start) begin
        pend_period_reg <= cnt_reg;
        pend_high_reg   <= high_reg;
      end

      valid_reg <= div_done;
      if (div_done) begin
        period_reg    <= pend_period_reg;
        high_time_reg <= pend_high_reg;
        duty_reg      <= div_q;
      end

      if (rise) begin
        stuck_high_reg <= 1'b0;
        stuck_low_reg  <= 1'b0;
      end
      if (timeout) begin
        state_reg      <= IDLE;
        stuck_high_reg <= sync2_reg;
        stuck_low_reg  <= ~sync2_reg;
        duty_reg       <= sync2_reg ? '1 : '0;
      end
    end
  end

  assign period     = period_reg;
  assign high_time  = high_time_reg;
  assign duty       = duty_reg;
  assign valid      = valid_reg;
  assign stuck_high = stuck_high_reg;
  assign stuck_low  = stuck_low_reg;

endmodule
